// File: rtl/vertex_hex_stream_q16.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// vertex_hex_stream_q16 : streaming affine -> axial hex -> cube round -> LOD
// Rev 1.0
//==============================================================================
module vertex_hex_stream_q16 #(
  parameter int TAG_W      = 8,
  parameter int LOD_LEVELS = 3,
  parameter int LOD_W      = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cfg_load,
  input  logic [0:1][0:3][31:0]            cfg_matrix,
  input  logic [31:0]                      cfg_inv_size,
  input  logic [0:LOD_LEVELS-1][31:0]      cfg_lod_thresh,
  output logic                             cfg_done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [31:0]                      in_x,
  input  logic [31:0]                      in_y,
  input  logic [31:0]                      in_z,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_sx,
  output logic [31:0]                      out_sy,
  output logic [31:0]                      out_q_f,
  output logic [31:0]                      out_r_f,
  output logic [31:0]                      out_s_f,
  output logic [31:0]                      out_q,
  output logic [31:0]                      out_r,
  output logic [31:0]                      out_s,
  output logic [LOD_W-1:0]                 out_lod,
  output logic                             out_sat,
  output logic [TAG_W-1:0]                 out_tag,
  output logic                             busy
);

  localparam logic [31:0] c_k1 = 32'd37837;
  localparam logic [31:0] c_k2 = 32'd21845;
  localparam logic [31:0] c_k3 = 32'd43691;

  function automatic logic signed [66:0] sext(input logic [31:0] v);
    return $signed({{35{v[31]}}, v});
  endfunction

  logic [0:1][0:3][31:0]        m_q;
  logic [31:0]                  inv_q;
  logic [0:LOD_LEVELS-1][31:0]  thr_q;
  logic                         hold_q, cfg_done_q, cfg_take;

  logic                         v1_q, v2_q, v3_q, v4_q, adv;
  logic [31:0]                  s1_sx_q, s1_sy_q;
  logic                         s1_sat_q;
  logic [TAG_W-1:0]             s1_tag_q;
  logic [31:0]                  s2_sx_q, s2_sy_q, s2_qt_q, s2_rt_q, s2_d2_q;
  logic                         s2_sat_q;
  logic [TAG_W-1:0]             s2_tag_q;
  logic [31:0]                  s3_sx_q, s3_sy_q, s3_qf_q, s3_rf_q, s3_sf_q;
  logic [LOD_W-1:0]             s3_lod_q;
  logic                         s3_sat_q;
  logic [TAG_W-1:0]             s3_tag_q;
  logic [31:0]                  s4_sx_q, s4_sy_q, s4_qf_q, s4_rf_q, s4_sf_q;
  logic [31:0]                  s4_q_q, s4_r_q, s4_s_q;
  logic [LOD_W-1:0]             s4_lod_q;
  logic                         s4_sat_q;
  logic [TAG_W-1:0]             s4_tag_q;

  logic [0:1][31:0]             s1_xy_d;
  logic                         s1_sat_d;
  logic signed [66:0]           s1_acc, s1_sh;
  logic [31:0]                  s2_qt_d, s2_rt_d, s2_d2_d;
  logic signed [66:0]           sq_sum;
  logic [34:0]                  d2_wide;
  logic [31:0]                  s3_qf_d, s3_rf_d, s3_sf_d;
  logic [LOD_W-1:0]             s3_lod_d;
  logic [0:2][31:0]             f;
  logic [31:0]                  rn [3];
  logic signed [66:0]           dd [3];
  logic signed [66:0]           dl;
  logic [31:0]                  s4_q_d, s4_r_d, s4_s_d;

  assign adv      = !v4_q || out_ready;
  assign in_ready = adv && !cfg_load;
  assign busy     = v1_q | v2_q | v3_q | v4_q;
  // hold_q limits a long cfg_load to a single latch/pulse
  assign cfg_take = cfg_load && !busy && !hold_q;
  assign cfg_done = cfg_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q        <= '0;
      inv_q      <= '0;
      thr_q      <= '0;
      hold_q     <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= cfg_take;
      if (cfg_take) begin
        m_q    <= cfg_matrix;
        inv_q  <= cfg_inv_size;
        thr_q  <= cfg_lod_thresh;
        hold_q <= 1'b1;
      end else if (!cfg_load) begin
        hold_q <= 1'b0;
      end
    end
  end

  always_comb begin
    s1_sat_d = 1'b0;
    s1_xy_d  = '0;
    s1_acc   = '0;
    s1_sh    = '0;
    for (int r = 0; r < 2; r++) begin
      s1_acc = sext(in_x) * sext(m_q[r][0]) + sext(in_y) * sext(m_q[r][1])
             + sext(in_z) * sext(m_q[r][2]) + (sext(m_q[r][3]) <<< 16);
      s1_sh  = s1_acc >>> 16;
      if ((&s1_sh[66:31]) || !(|s1_sh[66:31])) begin
        s1_xy_d[r] = s1_sh[31:0];
      end else begin
        s1_xy_d[r] = s1_sh[66] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        s1_sat_d   = 1'b1;
      end
    end
  end

  always_comb begin
    s2_qt_d = 32'(((sext(c_k1) * sext(s1_sx_q)) - (sext(c_k2) * sext(s1_sy_q))) >>> 16);
    s2_rt_d = 32'((sext(c_k3) * sext(s1_sy_q)) >>> 16);
    sq_sum  = sext(s1_sx_q) * sext(s1_sx_q) + sext(s1_sy_q) * sext(s1_sy_q);
    d2_wide = 35'(sq_sum >>> 32);
    s2_d2_d = (|d2_wide[34:32]) ? 32'hFFFF_FFFF : d2_wide[31:0];
  end

  always_comb begin
    s3_qf_d  = 32'((sext(s2_qt_q) * sext(inv_q)) >>> 16);
    s3_rf_d  = 32'((sext(s2_rt_q) * sext(inv_q)) >>> 16);
    s3_sf_d  = -(s3_qf_d + s3_rf_d);
    s3_lod_d = '0;
    for (int i = 0; i < LOD_LEVELS; i++) begin
      if (s2_d2_q > thr_q[i]) s3_lod_d = s3_lod_d + LOD_W'(1);
    end
  end

  // The axis with the largest rounding error is rebuilt from the other two.
  always_comb begin
    f  = {s3_qf_q, s3_rf_q, s3_sf_q};
    dl = '0;
    for (int i = 0; i < 3; i++) begin
      rn[i] = 32'((sext(f[i]) + 67'sd32768) >>> 16);
      dl    = (sext(rn[i]) <<< 16) - sext(f[i]);
      dd[i] = dl[66] ? -dl : dl;
    end
    s4_q_d = rn[0];
    s4_r_d = rn[1];
    s4_s_d = rn[2];
    if (dd[0] > dd[1] && dd[0] > dd[2]) s4_q_d = -rn[1] - rn[2];
    else if (dd[1] > dd[2])             s4_r_d = -rn[0] - rn[2];
    else                                s4_s_d = -rn[0] - rn[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0; s1_sx_q <= '0; s1_sy_q <= '0; s1_sat_q <= 1'b0; s1_tag_q <= '0;
      v2_q <= 1'b0; s2_sx_q <= '0; s2_sy_q <= '0; s2_qt_q <= '0; s2_rt_q <= '0;
      s2_d2_q <= '0; s2_sat_q <= 1'b0; s2_tag_q <= '0;
      v3_q <= 1'b0; s3_sx_q <= '0; s3_sy_q <= '0; s3_qf_q <= '0; s3_rf_q <= '0;
      s3_sf_q <= '0; s3_lod_q <= '0; s3_sat_q <= 1'b0; s3_tag_q <= '0;
      v4_q <= 1'b0; s4_sx_q <= '0; s4_sy_q <= '0; s4_qf_q <= '0; s4_rf_q <= '0;
      s4_sf_q <= '0; s4_q_q <= '0; s4_r_q <= '0; s4_s_q <= '0; s4_lod_q <= '0;
      s4_sat_q <= 1'b0; s4_tag_q <= '0;
    end else if (adv) begin
      v1_q <= in_valid && in_ready; s1_sx_q <= s1_xy_d[0]; s1_sy_q <= s1_xy_d[1];
      s1_sat_q <= s1_sat_d; s1_tag_q <= in_tag;
      v2_q <= v1_q; s2_sx_q <= s1_sx_q; s2_sy_q <= s1_sy_q; s2_qt_q <= s2_qt_d;
      s2_rt_q <= s2_rt_d; s2_d2_q <= s2_d2_d; s2_sat_q <= s1_sat_q; s2_tag_q <= s1_tag_q;
      v3_q <= v2_q; s3_sx_q <= s2_sx_q; s3_sy_q <= s2_sy_q; s3_qf_q <= s3_qf_d;
      s3_rf_q <= s3_rf_d; s3_sf_q <= s3_sf_d; s3_lod_q <= s3_lod_d;
      s3_sat_q <= s2_sat_q; s3_tag_q <= s2_tag_q;
      v4_q <= v3_q; s4_sx_q <= s3_sx_q; s4_sy_q <= s3_sy_q; s4_qf_q <= s3_qf_q;
      s4_rf_q <= s3_rf_q; s4_sf_q <= s3_sf_q; s4_q_q <= s4_q_d; s4_r_q <= s4_r_d;
      s4_s_q <= s4_s_d; s4_lod_q <= s3_lod_q; s4_sat_q <= s3_sat_q; s4_tag_q <= s3_tag_q;
    end
  end

  assign out_valid = v4_q;
  assign out_sx    = s4_sx_q;
  assign out_sy    = s4_sy_q;
  assign out_q_f   = s4_qf_q;
  assign out_r_f   = s4_rf_q;
  assign out_s_f   = s4_sf_q;
  assign out_q     = s4_q_q;
  assign out_r     = s4_r_q;
  assign out_s     = s4_s_q;
  assign out_lod   = s4_lod_q;
  assign out_sat   = s4_sat_q;
  assign out_tag   = s4_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_vertex_hex_stream_q16.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_vertex_hex_stream_q16 : directed self-checking bench for the hex pipeline
// Rev 1.0
//==============================================================================
module tb_vertex_hex_stream_q16;
  localparam int TAG_W = 8, LOD_LEVELS = 3, LOD_W = 2;

  typedef logic [0:1][0:3][31:0]       mat_t;
  typedef logic [0:LOD_LEVELS-1][31:0] thr_t;
  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] sx, sy, qf, rf, sf, q, r, s;
    logic [1:0]  lod;
    logic        sat;
  } rec_t;

  logic clk = 1'b0, reset_n = 1'b0, cfg_load = 1'b0, cfg_done;
  mat_t cfg_matrix = '0;
  logic [31:0] cfg_inv_size = '0;
  thr_t cfg_lod_thresh = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_sat, busy;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [31:0] out_sx, out_sy, out_q_f, out_r_f, out_s_f, out_q, out_r, out_s;
  logic [LOD_W-1:0] out_lod;

  vertex_hex_stream_q16 #(.TAG_W(TAG_W), .LOD_LEVELS(LOD_LEVELS), .LOD_W(LOD_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_matrix(cfg_matrix),
    .cfg_inv_size(cfg_inv_size), .cfg_lod_thresh(cfg_lod_thresh), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_sx(out_sx),
    .out_sy(out_sy), .out_q_f(out_q_f), .out_r_f(out_r_f), .out_s_f(out_s_f),
    .out_q(out_q), .out_r(out_r), .out_s(out_s), .out_lod(out_lod), .out_sat(out_sat),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_errors = 0;
  rec_t q_out[$];
  logic busy_at_latch;
  mat_t ident, satm, dbl;
  thr_t th;
  rec_t rec;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready)
      q_out.push_back(rec_t'({out_tag, out_sx, out_sy, out_q_f, out_r_f, out_s_f,
                              out_q, out_r, out_s, out_lod, out_sat}));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pop(output rec_t r);
    if (q_out.size() > 0) r = q_out.pop_front();
    else r = '0;
  endtask

  task automatic wait_out(input int n);
    int c;
    c = 0;
    while (q_out.size() < n && c < 60) begin step(); c++; end
    if (q_out.size() < n) check_eq("wait_out", 64'(q_out.size()), 64'(n));
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [7:0] tag);
    int n;
    n = 0;
    in_x = x; in_y = y; in_z = z; in_tag = tag; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!in_ready) check_eq("send_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input mat_t m, input logic [31:0] inv, input thr_t t);
    int   n;
    logic b;
    n = 0;
    cfg_matrix = m; cfg_inv_size = inv; cfg_lod_thresh = t; cfg_load = 1'b1;
    do begin b = busy; step(); n++; end while (!cfg_done && n < 100);
    if (!cfg_done) check_eq("cfg_timeout", 64'(cfg_done), 64'd1);
    busy_at_latch = b;
    cfg_load = 1'b0;
    step();
    check_eq("cfg_done_pulse", 64'(cfg_done), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    ident = '0; ident[0][0] = 32'h10000; ident[1][1] = 32'h10000;
    satm  = '0; satm[0][0]  = 32'h7FFF0000; satm[1][1] = 32'h10000;
    dbl   = '0; dbl[0][0]   = 32'h20000; dbl[1][1] = 32'h20000;
    th[0] = 32'd4; th[1] = 32'd100; th[2] = 32'd10000;

    // reset state
    repeat (3) step();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_cfg_done", 64'(cfg_done), 64'd0);
    check_eq("rst_out_sx", 64'(out_sx), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    reset_n = 1'b1;
    step();
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);

    // identity, axis point, exact latency
    load_cfg(ident, 32'h10000, th);
    in_x = 32'h30000; in_y = '0; in_z = '0; in_tag = 8'hA1; in_valid = 1'b1;
    #1;
    check_eq("lat_accept_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("lat_early", 64'(out_valid), 64'd0);
      step();
    end
    check_eq("lat_n4", 64'(out_valid), 64'd1);
    wait_out(1);
    pop(rec);
    check_eq("id_tag", 64'(rec.tag), 64'hA1);
    check_eq("id_sx", 64'(rec.sx), 64'h30000);
    check_eq("id_sy", 64'(rec.sy), 64'h0);
    check_eq("id_qf", 64'(rec.qf), 64'd113511);
    check_eq("id_rf", 64'(rec.rf), 64'd0);
    check_eq("id_sf", 64'(rec.sf), 64'hFFFE4499);
    check_eq("id_q", 64'(rec.q), 64'd2);
    check_eq("id_r", 64'(rec.r), 64'd0);
    check_eq("id_s", 64'(rec.s), 64'hFFFFFFFE);
    check_eq("id_lod", 64'(rec.lod), 64'd1);
    check_eq("id_sat", 64'(rec.sat), 64'd0);

    // LOD classification
    send(32'h30000, 32'h40000, 32'h0, 8'h01);
    send(32'h0, 32'h0, 32'h0, 8'h02);
    send(32'hC80000, 32'h0, 32'h0, 8'h03);
    wait_out(3);
    pop(rec);
    check_eq("lod_34_lod", 64'(rec.lod), 64'd1);
    check_eq("lod_34_qf", 64'(rec.qf), 64'd26131);
    check_eq("lod_34_rf", 64'(rec.rf), 64'd174764);
    check_eq("lod_34_sf", 64'(rec.sf), 64'hFFFCEF41);
    check_eq("lod_34_qrs", {rec.q, rec.r}, {32'd0, 32'd3});
    check_eq("lod_34_s", 64'(rec.s), 64'hFFFFFFFD);
    pop(rec);
    check_eq("lod_00_lod", 64'(rec.lod), 64'd0);
    check_eq("lod_00_tag", 64'(rec.tag), 64'h02);
    pop(rec);
    check_eq("lod_200_lod", 64'(rec.lod), 64'd3);
    check_eq("lod_200_sx", 64'(rec.sx), 64'hC80000);

    // saturation
    load_cfg(satm, 32'h10000, th);
    send(32'h7FFF0000, 32'h0, 32'h0, 8'h04);
    send(32'h80010000, 32'h0, 32'h0, 8'h05);
    wait_out(2);
    pop(rec);
    check_eq("sat_pos_sx", 64'(rec.sx), 64'h7FFFFFFF);
    check_eq("sat_pos_flag", 64'(rec.sat), 64'd1);
    check_eq("sat_pos_sy", 64'(rec.sy), 64'd0);
    pop(rec);
    check_eq("sat_neg_sx", 64'(rec.sx), 64'h80000000);
    check_eq("sat_neg_flag", 64'(rec.sat), 64'd1);
    check_eq("sat_neg_tag", 64'(rec.tag), 64'h05);

    // backpressure: out_ready low for cycles 5-10
    load_cfg(ident, 32'h10000, th);
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i) << 16, 32'h0, 32'h0, 8'(i));
      end
      begin
        logic        have_snap, saw_block;
        logic [39:0] snap_ts;
        logic [31:0] snap_qf;
        have_snap = 1'b0; saw_block = 1'b0; snap_ts = '0; snap_qf = '0;
        repeat (4) step();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
          step();
          if (out_valid) begin
            if (have_snap) begin
              check_eq("bp_hold_tag_sx", 64'({out_tag, out_sx}), 64'(snap_ts));
              check_eq("bp_hold_qf", 64'(out_q_f), 64'(snap_qf));
            end else begin
              snap_ts = {out_tag, out_sx}; snap_qf = out_q_f; have_snap = 1'b1;
            end
            if (!in_ready) saw_block = 1'b1;
          end
        end
        check_eq("bp_in_ready_low", 64'(saw_block), 64'd1);
        out_ready = 1'b1;
      end
    join
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      pop(rec);
      check_eq("bp_order_tag", 64'(rec.tag), 64'(i));
      check_eq("bp_order_sx", 64'(rec.sx), 64'(32'(i) << 16));
    end
    repeat (6) step();
    check_eq("bp_no_dup", 64'(q_out.size()), 64'd0);

    // config under load
    send(32'h10000, 32'h0, 32'h0, 8'h10);
    send(32'h10000, 32'h0, 32'h0, 8'h11);
    send(32'h10000, 32'h0, 32'h0, 8'h12);
    cfg_matrix = dbl; cfg_load = 1'b1;
    #1;
    check_eq("cl_in_ready", 64'(in_ready), 64'd0);
    check_eq("cl_busy", 64'(busy), 64'd1);
    load_cfg(dbl, 32'h10000, th);
    check_eq("cl_latch_idle", 64'(busy_at_latch), 64'd0);
    send(32'h10000, 32'h0, 32'h0, 8'h13);
    wait_out(4);
    for (int i = 0; i < 3; i++) begin
      pop(rec);
      check_eq("cl_old_tag", 64'(rec.tag), 64'(8'h10 + i));
      check_eq("cl_old_sx", 64'(rec.sx), 64'h10000);
    end
    pop(rec);
    check_eq("cl_new_tag", 64'(rec.tag), 64'h13);
    check_eq("cl_new_sx", 64'(rec.sx), 64'h20000);

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) send(32'h10000, 32'h0, 32'h0, 8'(8'h20 + i));
    reset_n = 1'b0;
    #1;
    check_eq("ar_out_valid", 64'(out_valid), 64'd0);
    check_eq("ar_busy", 64'(busy), 64'd0);
    check_eq("ar_cfg_done", 64'(cfg_done), 64'd0);
    q_out.delete();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    check_eq("ar_no_stale", 64'(q_out.size()), 64'd0);
    send(32'h50000, 32'h0, 32'h0, 8'hAA);
    wait_out(1);
    pop(rec);
    check_eq("ar_first_tag", 64'(rec.tag), 64'hAA);
    check_eq("ar_cfg_cleared_sx", 64'(rec.sx), 64'd0);
    repeat (6) step();
    check_eq("ar_single", 64'(q_out.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vertex_hex_stream_q16.md
# vertex_hex_stream_q16

Streaming, parametrised successor to the batch vertex-to-hex stage. Accepts one vertex per cycle over a valid/ready handshake and runs a fixed 4-stage pipeline:
- affine transform with saturation;
- axial hex conversion using a reciprocal of hex size (no divider);
- cube rounding to integer hex cells;
- multi-level LOD classification.

It sits between vertex fetch and the hex rasteriser.

## Interface
- `TAG_W`, default 8: width of the sideband tag carried with each vertex.
- `LOD_LEVELS`, default 3: number of distance thresholds; LOD output ranges 0..`LOD_LEVELS`.
- `LOD_W`, default 2: width of `out_lod`; must satisfy 2^`LOD_W` > `LOD_LEVELS`.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_load` in 1: request to latch the configuration inputs.
- `cfg_matrix` in 32x[0:1][0:3]: rows 0-1 of the transform, Q16.16 signed.
- `cfg_inv_size` in 32: 1/hex_size, Q16.16 signed.
- `cfg_lod_thresh` in 32x[0:`LOD_LEVELS`-1]: ascending unsigned squared-distance thresholds, integer units.
- `cfg_done` out 1: one-cycle pulse when the configuration is latched.
- `in_valid`, `in_ready`, 1 bit each: input handshake.
- `in_x`, `in_y`, `in_z` in 32 each: Q16.16 signed vertex.
- `in_tag` in `TAG_W`: passed through unchanged.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_sx`, `out_sy` out 32: screen position, Q16.16.
- `out_q_f`, `out_r_f`, `out_s_f` out 32: fractional axial/cube coordinates, Q16.16.
- `out_q`, `out_r`, `out_s` out 32: rounded integer cube coordinates (two's complement integers, not Q16.16).
- `out_lod` out `LOD_W`; `out_sat` out 1; `out_tag` out `TAG_W`.
- `busy` out 1: any pipeline stage valid.

## Operation
- Constants (Q16.16): K1 = sqrt3/3 = 37837; K2 = 1/3 = 21845; K3 = 2/3 = 43691.
- **Stage 1:** `acc = x*m[r][0] + y*m[r][1] + z*m[r][2] + (m[r][3]<<<16)`.
  - Signed, at least 67 bits.
  - `sx`/`sy` = `acc>>>16`, saturated to [0x80000000, 0x7FFFFFFF].
  - `sat` = 1 if either row clipped.
- **Stage 2:** `qt = (K1*sx - K2*sy)>>>16`; `rt = (K3*sy)>>>16`.
  - Squared distance: `d2 = (sx*sx + sy*sy)>>32`, unsigned, saturated to 32 bits.
- **Stage 3:** `q_f = (qt*inv)>>>16`; `r_f = (rt*inv)>>>16`; `s_f = -(q_f + r_f)`.
  - All three wrap to 32 bits, no saturation.
  - `lod` = count of thresholds t with `d2 > t`.
- **Stage 4 (cube rounding):**
  - `rq = (q_f + 0x8000)>>>16`, and likewise `rr`, `rs`.
  - `dq = |(rq<<16) - q_f|`, and likewise `dr`, `ds`.
  - If `dq > dr` and `dq > ds`: `q = -rr - rs`.
  - Else if `dr > ds`: `r = -rq - rs`.
  - Else: `s = -rq - rr`.
  - Invariant: `q + r + s == 0` always.
- Tag and `sat` travel with the vertex unchanged.
- **Configuration:**
  - While `cfg_load` = 1, `in_ready` = 0.
  - Registers latch on the first cycle with `cfg_load` = 1 and `busy` = 0.
  - `cfg_done` pulses the following cycle.
  - A `cfg_load` held while busy waits; the pipeline drains, it never corrupts in-flight data.
- **Reset values:** all stage valids 0, config registers 0, all outputs 0. Takes effect immediately on `reset_n` low, including mid-stream; in-flight vertices are discarded.

## Timing
- Latency: a vertex accepted in cycle N appears with `out_valid` = 1 in cycle N+4 if unstalled.
- Throughput: 1 vertex/cycle.
- Global stall: `adv = !v4 | out_ready`. All stages shift only when `adv` = 1.
- `in_ready = adv & !cfg_load`. Bubbles are not collapsed.
- **Output stability:** outputs are registered. While `out_valid` = 1 and `out_ready` = 0, all `out_*` stay stable.
- Transfers happen on `in_valid & in_ready` and on `out_valid & out_ready`; simultaneous accept and emit in one cycle is legal.
- `busy` = OR of the 4 stage valids.
- The configuration in force for a vertex is the one latched before that vertex was accepted.

## Test plan
- **Identity, axis point:** identity matrix, `inv` = 0x10000, x = 0x30000, y = z = 0.
  - sx = 0x30000, q_f = 113511, r_f = 0, s_f = -113511.
  - (q, r, s) = (2, 0, -2).
  - `out_valid` exactly 4 cycles after accept.
- **LOD:** thresholds {4, 100, 10000}.
  - (sx, sy) = (3.0, 4.0), d2 = 25 → lod 1.
  - (0, 0) → lod 0.
  - (200.0, 0) → lod 3.
- **Saturation:** m[0][0] = 0x7FFF0000, x = 0x7FFF0000.
  - `out_sx` = 0x7FFFFFFF, `out_sat` = 1.
  - Negating x gives 0x80000000.
- **Backpressure:** stream 8 vertices with tags 0-7; hold `out_ready` = 0 for cycles 5-10.
  - `in_ready` drops once 4 stages are full.
  - All 8 emerge in order with no loss or duplication.
  - Outputs are held stable during the stall.
- **Config under load:** assert `cfg_load` with 3 vertices in flight.
  - `in_ready` = 0 immediately.
  - Latch occurs only after `busy` = 0.
  - `cfg_done` = 1 for one cycle.
  - Vertices accepted before the load use the old matrix; those after use the new one.
- **Reset mid-operation:** pull `reset_n` low with 4 vertices in flight.
  - `out_valid`, `busy` and `cfg_done` = 0 asynchronously.
  - After release, the first output comes only from newly accepted input.
